// File: rtl/eth_tx_pause_insert.sv
// Inserts IEEE 802.3x PAUSE frames into an AXI-Stream TX path between the TX FIFO and the MAC.
// Requests are held off until the frame in progress has ended, then sent after a one-cycle bubble.
module eth_tx_pause_insert #(
    parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
    parameter int unsigned PAUSE_LEN = 60
) (
    input  logic        tx_clk,
    input  logic        tx_rst,

    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,

    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,

    input  logic        pause_req,
    input  logic [15:0] pause_quanta,
    output logic        pause_busy,
    output logic        pause_sent
);

    localparam int unsigned      CNT_W    = $clog2(PAUSE_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAUSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        PAUSE
    } state_t;

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [15:0]      q_pend_q, q_pend_d;
    logic [15:0]      q_frame_q, q_frame_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sent_q, sent_d;

    logic             pass_en;
    logic             s_fire;
    logic             m_fire;
    logic             pause_last;
    logic [31:0]      byte_idx;
    logic [7:0]       pause_byte;

    // Pass-through is only allowed when no PAUSE is waiting to go out.
    assign pass_en    = (state_q == PASS) || ((state_q == IDLE) && !pending_q);
    assign s_fire     = pass_en && s_axis_tvalid && m_axis_tready;
    assign m_fire     = (state_q == PAUSE) && m_axis_tready;
    assign pause_last = (cnt_q == CNT_LAST);
    assign byte_idx   = 32'(cnt_q);

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            q_pend_q  <= '0;
            q_frame_q <= '0;
            cnt_q     <= '0;
            sent_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            q_pend_q  <= q_pend_d;
            q_frame_q <= q_frame_d;
            cnt_q     <= cnt_d;
            sent_q    <= sent_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        q_pend_d  = q_pend_q;
        q_frame_d = q_frame_q;
        cnt_d     = cnt_q;
        sent_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = PAUSE;
                    cnt_d     = '0;
                    q_frame_d = q_pend_q;
                    pending_d = 1'b0;
                end else if (s_fire && !s_axis_tlast) begin
                    state_d = PASS;
                end
            end
            PASS: begin
                if (s_fire && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            PAUSE: begin
                if (m_fire) begin
                    if (pause_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        sent_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A request landing on the IDLE->PAUSE cycle overrides the pending clear above.
        if (pause_req) begin
            pending_d = 1'b1;
            q_pend_d  = pause_quanta;
        end
    end

    always_comb begin
        pause_byte = 8'h00;
        unique case (byte_idx)
            32'd0:   pause_byte = 8'h01;
            32'd1:   pause_byte = 8'h80;
            32'd2:   pause_byte = 8'hC2;
            32'd3:   pause_byte = 8'h00;
            32'd4:   pause_byte = 8'h00;
            32'd5:   pause_byte = 8'h01;
            32'd6:   pause_byte = SRC_MAC[47:40];
            32'd7:   pause_byte = SRC_MAC[39:32];
            32'd8:   pause_byte = SRC_MAC[31:24];
            32'd9:   pause_byte = SRC_MAC[23:16];
            32'd10:  pause_byte = SRC_MAC[15:8];
            32'd11:  pause_byte = SRC_MAC[7:0];
            32'd12:  pause_byte = 8'h88;
            32'd13:  pause_byte = 8'h08;
            32'd14:  pause_byte = 8'h00;
            32'd15:  pause_byte = 8'h01;
            32'd16:  pause_byte = q_frame_q[15:8];
            32'd17:  pause_byte = q_frame_q[7:0];
            default: pause_byte = 8'h00;
        endcase
    end

    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        m_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        if (state_q == PAUSE) begin
            m_axis_tdata  = pause_byte;
            m_axis_tlast  = pause_last;
            m_axis_tuser  = 1'b0;
            m_axis_tvalid = !tx_rst;
        end else if (pass_en) begin
            m_axis_tvalid = s_axis_tvalid && !tx_rst;
            s_axis_tready = m_axis_tready && !tx_rst;
        end
    end

    assign pause_busy = pending_q || (state_q == PAUSE);
    assign pause_sent = sent_q;

endmodule

// File: doc/eth_tx_pause_insert.md
ETH_TX_PAUSE_INSERT -- requirements
Module: eth_tx_pause_insert

Interface
REQ-001 SHALL have parameter SRC_MAC, default 48'h02_00_00_00_00_01: source MAC address placed in generated PAUSE frames.
REQ-002 SHALL have parameter PAUSE_LEN, default 60: generated frame length in bytes, excluding FCS; legal range 18-1514.
REQ-003 SHALL have port tx_clk, input, 1: clock for all logic.
REQ-004 SHALL have port tx_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port s_axis_tdata, input, 8: frame data from the TX FIFO output.
REQ-006 SHALL have ports s_axis_tvalid (input, 1), s_axis_tready (output, 1), s_axis_tlast (input, 1) and s_axis_tuser (input, 1): AXI-Stream control for the FIFO side.
REQ-007 SHALL have port m_axis_tdata, output, 8: frame data to the MAC TX input.
REQ-008 SHALL have ports m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1) and m_axis_tuser (output, 1): AXI-Stream control for the MAC side.
REQ-009 SHALL have port pause_req, input, 1: single-cycle pulse that requests one PAUSE frame.
REQ-010 SHALL have port pause_quanta, input, 16: quanta value, sampled on pause_req.
REQ-011 SHALL have port pause_busy, output, 1: high while a request is pending or a PAUSE frame is being sent.
REQ-012 SHALL have port pause_sent, output, 1: single-cycle pulse issued on acceptance of the last PAUSE byte.

Function
REQ-013 SHALL implement three states, IDLE, PASS and PAUSE, together with a pending flag, a quanta latch (q_pend), a frame quanta register (q_frame) and a byte counter cnt, which is wide enough for PAUSE_LEN-1.
REQ-014 SHALL behave as follows in IDLE with pending=0:
- m_axis_* are combinational copies of s_axis_*.
- s_axis_tready = m_axis_tready.
- An accepted beat with tlast=0 moves the block to PASS.
- An accepted beat with tlast=1 keeps the block in IDLE.
REQ-015 SHALL behave as follows in PASS:
- Same pass-through as IDLE.
- The accepted beat with tlast=1 returns the block to IDLE.
- pause_req never interrupts a frame in progress.
REQ-016 SHALL behave as follows in IDLE with pending=1:
- s_axis_tready=0 and m_axis_tvalid=0.
- Next cycle: state=PAUSE, cnt=0, q_frame<=q_pend, pending<=0.
- This gives a one-cycle bubble.
REQ-017 SHALL drive the PAUSE state as follows:
- m_axis_tvalid=1, m_axis_tuser=0, s_axis_tready=0.
- m_axis_tlast=(cnt==PAUSE_LEN-1).
- cnt increments on each m_axis_tvalid&&m_axis_tready.
REQ-018 SHALL output PAUSE bytes by cnt as follows:
- 0-5: 01 80 C2 00 00 01.
- 6-11: SRC_MAC, MSB first.
- 12-13: 88 08.
- 14-15: 00 01.
- 16-17: q_frame[15:8], q_frame[7:0].
- 18 and above: 00.
REQ-019 SHALL, on acceptance of the last PAUSE byte, go to IDLE, pulse pause_sent for one cycle and clear cnt.
REQ-020 SHALL, on pause_req, set pending=1 and q_pend<=pause_quanta in any state.
REQ-021 SHALL apply latest-wins to pause_req received while pending=1: only q_pend updates and only one frame is sent.
REQ-022 SHALL handle pause_req received during PAUSE by leaving q_frame unchanged and sending a second frame after the current one ends.
REQ-023 SHALL, when pause_req coincides with the IDLE→PAUSE transition cycle, leave pending=1 so that another frame follows.
REQ-024 SHALL hold m_axis_tdata/tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 SHALL drive pause_busy = pending OR (state==PAUSE), registered-state based.
REQ-026 SHALL pass s_axis_tuser to m_axis_tuser unmodified; a bad-frame marker is forwarded and never generated.
REQ-027 SHALL NOT start a PAUSE frame in the cycle in which an IDLE single-beat frame (tlast=1) is accepted; that request is honoured on the following cycle.

Reset
REQ-028 SHALL, on tx_rst high, asynchronously set: state=IDLE, pending=0, cnt=0, q_pend=0, q_frame=0, pause_sent=0, pause_busy=0.
REQ-029 SHALL, during reset, hold m_axis_tvalid=0 and s_axis_tready=0 regardless of inputs.
REQ-030 SHALL, on reset during PAUSE or PASS, abandon the frame immediately with no tlast emitted; the MAC shares tx_rst, so it is reset too.
REQ-031 SHALL, on the first cycle after reset release, behave as IDLE pass-through.

Verification
REQ-032 Idle request: pause_req with quanta=16'hFFFF, m_axis_tready=1 → after one bubble cycle, 60 beats with bytes 16-17 = FF FF, tlast on beat 60, pause_sent one cycle after the last accept, pause_busy low afterwards.
REQ-033 Mid-frame request: 100-byte frame streaming; pause_req at byte 10 → all 100 bytes pass unmodified, tlast at byte 100, then bubble, then PAUSE frame, and s_axis_tready=0 throughout PAUSE.
REQ-034 Latest wins: pause_req quanta 0x0010 then 0x0020 during one frame → exactly one PAUSE frame, carrying 00 20.
REQ-035 Backpressure: m_axis_tready toggles 1/0 each cycle during PAUSE → 60 distinct bytes, data stable in stalled cycles, 120 cycles total.
REQ-036 Request during PAUSE: pause_req 0x0005 at cnt=30 of a frame with quanta 0x0001 → first frame carries 00 01, second frame carries 00 05, pause_sent pulses twice.
REQ-037 Reset mid-PAUSE: tx_rst asserted at cnt=20 → m_axis_tvalid=0 immediately; after release, pending=0, pass-through works, and no PAUSE is emitted.
